mem_access_stage: RTL

- Fourth pipeline stage. Sits between execute and the combinational writeback stage.
- Accepts one execute-stage result at a time and performs any load or store over a request/response data-memory port.
- Loads are byte-lane aligned and sign- or zero-extended.
- Presents a registered MEM/WB bundle: read data, ALU data, memOrReg select, rd, regWrite. Writeback consumes it the same cycle.

---
 rtl/mem_access_stage_pkg.sv | 55 +++++
 rtl/mem_access_stage_load_align.sv | 28 ++
 rtl/mem_access_stage.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types and helpers for the memory-access pipeline stage: operand sizes,
// FSM states, the latched operation and the MEM/WB bundle, plus byte-lane helpers.
package mem_pkg;

    localparam int BUS_DATA_WIDTH = 64;
    localparam int LANE_COUNT     = BUS_DATA_WIDTH / 8;
    localparam int LANE_BITS      = $clog2(LANE_COUNT);

    typedef enum logic [1:0] {BYTE, HALF, WORD, DWORD} mem_size_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;

    typedef struct packed {
        logic [BUS_DATA_WIDTH-1:0] alu_data;
        logic [BUS_DATA_WIDTH-1:0] store_data;
        logic                      mem_read;
        logic                      mem_write;
        mem_size_t                 size;
        logic                      is_unsigned;
        logic                      mem_or_reg;
        logic                      reg_write;
    } mem_op_t;

    typedef struct packed {
        logic                      valid;
        logic [BUS_DATA_WIDTH-1:0] read_data;
        logic [BUS_DATA_WIDTH-1:0] alu_data;
        logic                      mem_or_reg;
        logic                      reg_write;
    } wb_t;

    function automatic logic [LANE_BITS:0] size_bytes(input mem_size_t size);
        return 4'd1 << size;
    endfunction

    function automatic logic [LANE_COUNT-1:0] lane_mask(input mem_size_t size);
        return 8'hFF >> (4'd8 - size_bytes(size));
    endfunction

    // A misaligned lane is rounded down to the natural alignment of the access size.
    function automatic logic [LANE_BITS-1:0] align_lane(input logic [LANE_BITS-1:0] lane,
                                                        input mem_size_t size);
        logic [LANE_BITS:0] low_bits;
        low_bits = size_bytes(size) - 4'd1;
        return lane & ~low_bits[LANE_BITS-1:0];
    endfunction

    function automatic logic is_misaligned(input logic [LANE_BITS-1:0] lane,
                                           input mem_size_t size);
        logic [LANE_BITS:0] low_bits;
        low_bits = size_bytes(size) - 4'd1;
        return (lane & low_bits[LANE_BITS-1:0]) != 3'd0;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Combinational load aligner: selects the addressed bytes of a memory line and
// sign- or zero-extends them to the full bus width.
module load_align
    import mem_pkg::*;
(
    input  logic [LANE_BITS-1:0]      lane,
    input  mem_size_t                 size,
    input  logic                      is_unsigned,
    input  logic [BUS_DATA_WIDTH-1:0] line,
    output logic [BUS_DATA_WIDTH-1:0] data
);

    logic [BUS_DATA_WIDTH-1:0] shifted;

    assign shifted = line >> {lane, 3'b000};

    always_comb begin
        data = shifted;
        unique case (size)
            BYTE:    data = {{56{~is_unsigned & shifted[7]}},  shifted[7:0]};
            HALF:    data = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
            WORD:    data = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
            DWORD:   data = shifted;
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Fourth pipeline stage: performs loads/stores over a request/response data port
// and presents a registered MEM/WB bundle. Optional MEM_MISALIGN_TRAP_EN adds outMisaligned.
module mem_access_stage #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [BUS_DATA_WIDTH-1:0] inALUData,
    input  logic [BUS_DATA_WIDTH-1:0] inStoreData,
    input  logic                      inMemRead,
    input  logic                      inMemWrite,
    input  logic [1:0]                inMemSize,
    input  logic                      inMemUnsigned,
    input  logic                      inMemOrReg,
    input  logic                      inRegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] inRd,
    output logic                      memReqValid,
    input  logic                      memReqReady,
    output logic                      memReqWrite,
    output logic [BUS_DATA_WIDTH-1:0] memReqAddr,
    output logic [BUS_DATA_WIDTH-1:0] memReqData,
    output logic [7:0]                memReqStrobe,
    input  logic                      memRespValid,
    input  logic [BUS_DATA_WIDTH-1:0] memRespData,
    output logic                      outValid,
    output logic [BUS_DATA_WIDTH-1:0] outReadData,
    output logic [BUS_DATA_WIDTH-1:0] outALUData,
    output logic                      outMemOrReg,
    output logic                      outRegWrite,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                      outMisaligned,
`endif
    output logic [REG_ADDR_WIDTH-1:0] outRd
);

    import mem_pkg::*;

    mem_state_t                state_q, state_d;
    mem_op_t                   op_q, op_d;
    wb_t                       wb_q, wb_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [REG_ADDR_WIDTH-1:0] out_rd_q, out_rd_d;
    logic [LANE_BITS-1:0]      lane;
    logic [BUS_DATA_WIDTH-1:0] load_data;
    logic                      in_req;
    logic                      trap;

    assign lane   = align_lane(op_q.alu_data[LANE_BITS-1:0], op_q.size);
    assign in_req = (state_q == REQ);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = (inMemRead | inMemWrite)
                & is_misaligned(inALUData[LANE_BITS-1:0], mem_size_t'(inMemSize));
`else
    assign trap = 1'b0;
`endif

    load_align u_load_align (
        .lane        (lane),
        .size        (op_q.size),
        .is_unsigned (op_q.is_unsigned),
        .line        (memRespData),
        .data        (load_data)
    );

    // Request fields come only from latched state, so they stay stable across ready stalls.
    assign memReqValid  = in_req;
    assign memReqWrite  = in_req & op_q.mem_write;
    assign memReqAddr   = in_req ? {op_q.alu_data[BUS_DATA_WIDTH-1:LANE_BITS], 3'b000} : '0;
    assign memReqData   = in_req ? (op_q.store_data << {lane, 3'b000}) : '0;
    assign memReqStrobe = in_req ? (lane_mask(op_q.size) << lane) : '0;

    assign inReady     = (state_q == IDLE);
    assign outValid    = wb_q.valid;
    assign outReadData = wb_q.read_data;
    assign outALUData  = wb_q.alu_data;
    assign outMemOrReg = wb_q.mem_or_reg;
    assign outRegWrite = wb_q.reg_write;
    assign outRd       = out_rd_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        wb_d     = wb_q;
        out_rd_d = out_rd_q;
        wb_d.valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (inValid) begin
                    op_d = '{alu_data:    inALUData,
                             store_data:  inStoreData,
                             mem_read:    inMemRead,
                             mem_write:   inMemWrite,
                             size:        mem_size_t'(inMemSize),
                             is_unsigned: inMemUnsigned,
                             mem_or_reg:  inMemOrReg,
                             reg_write:   inRegWrite};
                    rd_d = inRd;
                    if ((inMemRead | inMemWrite) & ~trap) begin
                        state_d = REQ;
                    end else begin
                        // ALU results and trapped accesses both retire straight from IDLE.
                        wb_d     = '{valid: 1'b1, read_data: '0, alu_data: inALUData,
                                     mem_or_reg: inMemOrReg, reg_write: inRegWrite & ~trap};
                        out_rd_d = inRd;
                    end
                end
            end
            REQ: begin
                if (memReqReady) begin
                    if (op_q.mem_read) begin
                        state_d = WAIT;
                    end else begin
                        state_d  = IDLE;
                        wb_d     = '{valid: 1'b1, read_data: '0, alu_data: op_q.alu_data,
                                     mem_or_reg: op_q.mem_or_reg, reg_write: op_q.reg_write};
                        out_rd_d = rd_q;
                    end
                end
            end
            WAIT: begin
                if (memRespValid) begin
                    state_d  = IDLE;
                    wb_d     = '{valid: 1'b1, read_data: load_data, alu_data: op_q.alu_data,
                                 mem_or_reg: op_q.mem_or_reg, reg_write: op_q.reg_write};
                    out_rd_d = rd_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            wb_q     <= '0;
            out_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            wb_q     <= wb_d;
            out_rd_q <= out_rd_d;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic out_misaligned_q, out_misaligned_d;

    assign out_misaligned_d = wb_d.valid ? (inReady & trap) : out_misaligned_q;
    assign outMisaligned    = out_misaligned_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) out_misaligned_q <= 1'b0;
        else       out_misaligned_q <= out_misaligned_d;
    end
`endif

endmodule
